branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Resolution-side partner of the gshare predictor in the pipelined core.
- Records each fetched branch's prediction in an in-order tracking queue and compares it with the actual outcome when execute resolves the branch.
- Drives the predictor's training inputs (branch, pc, branch_taken).
- On a misprediction, raises a one-cycle flush with the corrected PC and discards all younger in-flight branches.

Parameters:
- PC_W, 6, width of instruction-memory PC (matches 64-entry imem and predictor index).
- DEPTH, 4, tracking-queue entries (power of two, ≥2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pred_valid  in  1  fetch pushes a predicted branch this cycle.
- pred_pc  in  PC_W  PC of the fetched branch.
- pred_taken  in  1  predictor output for that branch.
- pred_target  in  PC_W  decoded branch target.
- pred_ready  out  1  queue can accept a push (not full, state RUN).
- res_valid  in  1  execute resolves the oldest in-flight branch.
- res_taken  in  1  actual outcome (comparator/XNOR result).
- res_target  in  PC_W  actual target.
- upd_branch  out  1  training strobe to predictor.
- upd_pc  out  PC_W  PC for predictor update.
- upd_taken  out  1  actual outcome for predictor update.
- flush  out  1  kill wrong-path instructions.
- redirect_pc  out  PC_W  corrected fetch PC, valid while flush=1.
- underflow_err  out  1  sticky: res_valid seen with empty queue.
- branch_count  out  CNT_W  resolved branches, saturating.
- mispredict_count  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - queue emptied; state RUN.
  - All outputs 0: pred_ready becomes 1 on the first cycle after reset deasserts.
  - Counters 0; underflow_err 0.
- Queue:
  - Circular buffer of {pc, taken, target} with head/tail pointers of log2(DEPTH)+1 bits; full/empty derived from the MSB.
  - Push when pred_valid && pred_ready. A push while full is ignored and no state changes.
- Resolve (state RUN, res_valid, queue non-empty):
  - Pop the head.
  - mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
- Latency: all outputs are registered, one cycle after res_valid.
  - upd_branch=1 for exactly one cycle, with upd_pc=head.pc and upd_taken=res_taken.
  - branch_count increments; on mispredict, mispredict_count also increments. Both saturate at all-ones.
- Mispredict:
  - Next cycle: flush=1 for exactly one cycle.
  - redirect_pc = res_target if res_taken, else head.pc+1 (mod 2^PC_W, wraps 63→0).
  - Entire queue is cleared (all entries are younger and wrong-path).
  - A push in the same cycle as the mispredicting resolve is discarded.
- FSM:
  - RUN → FLUSH on mispredict.
  - FLUSH → RUN unconditionally after 1 cycle.
  - In FLUSH: pred_ready=0, and res_valid/pred_valid are ignored with no error.
- Simultaneous push and correct-resolve in RUN: both happen; occupancy unchanged. This is allowed even when full, because the pop frees a slot in the same cycle: pred_ready = !full || (res_valid && correct).
  - Implementation option: pred_ready = !full only. The bench must accept either, and the choice must be documented in the RTL header.
- res_valid with an empty queue in RUN: no pop, no update, underflow_err set until reset.
- Reset mid-operation: immediate clear of queue and FSM. Any pending flush/update is dropped.
- upd_branch, flush and redirect_pc are 0 in every cycle not described above.

Decomposition:
- Shared package bru_pkg: PC_W default; entry struct {pc, taken, target}; FSM encoding RUN=1'b0, FLUSH=1'b1.
- One natural sub-module, bru_track_fifo: parameterised circular queue with push/pop/clear and full/empty.
- The top module holds the compare, FSM, registered outputs and counters.

Test Plan:
- Push pc=5 taken=1 target=20; resolve taken=1 target=20 → next cycle upd_branch=1, upd_pc=5, upd_taken=1, flush=0, branch_count=1.
- Push pc=8 predicted not-taken, plus 2 younger pushes; resolve taken=1 target=40 → flush=1 one cycle, redirect_pc=40, queue empty, mispredict_count=1, pred_ready=0 that cycle.
- Push pc=63 predicted taken target=10; resolve taken=0 → flush=1, redirect_pc=0 (wrap), upd_taken=0.
- Fill DEPTH=4 entries; 5th push with no resolve → ignored, pred_ready=0. Resolve 4 correct → upd_pc sequence matches push order, queue empty.
- res_valid on empty queue → no upd_branch, underflow_err=1 and held. Assert reset mid-stream with 3 entries → all outputs 0 asynchronously, queue empty after release.
- Mispredicting resolve coincident with pred_valid → pushed entry discarded: a following res_valid sets underflow_err.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: tracking-queue entry layout and FSM encoding.
package bru_pkg;

  localparam int BRU_PC_W = 6;

  typedef struct packed {
    logic [BRU_PC_W-1:0] pc;
    logic                taken;
    logic [BRU_PC_W-1:0] target;
  } entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/bru_track_fifo.sv
// In-order circular queue of predicted branches with push/pop/clear.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module bru_track_fifo #(
  parameter int DAT_W = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [DAT_W-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [DAT_W-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      head_q, head_d;
  logic [AW:0]      tail_q, tail_d;
  logic [DAT_W-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (head_q == tail_q);
  assign full_o     = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign head_dat_o = mem_q[head_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push while full is legal then.
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && !clear_i && (!full_o || do_pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (do_pop)  head_d = head_q + 1'b1;
      if (do_push) tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares resolved branches against queued predictions, trains the predictor and flushes on mispredict.
// All outputs registered one cycle after res_valid; pred_ready is also high when full if a correct resolve pops this cycle.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W  = BRU_PC_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             upd_branch,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             underflow_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  state_t                   state_q, state_d;
  logic                     live_q;
  entry_t                   push_ent, head_ent;
  logic [$bits(entry_t)-1:0] head_raw;
  logic                     full, empty;
  logic                     in_run, resolve, mispred, correct, push;

  logic             upd_branch_q, upd_branch_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic             flush_q, flush_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign push_ent = '{pc: pred_pc, taken: pred_taken, target: pred_target};
  assign head_ent = entry_t'(head_raw);

  assign in_run  = (state_q == RUN);
  assign resolve = in_run && res_valid && !empty;
  assign mispred = resolve && ((head_ent.taken != res_taken) ||
                               (res_taken && (head_ent.target != res_target)));
  assign correct = resolve && !mispred;

  // live_q keeps pred_ready low while reset is held and for the cycle it is released in.
  assign pred_ready = live_q && in_run && (!full || correct);
  assign push       = pred_valid && pred_ready;

  bru_track_fifo #(
    .DAT_W ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_track_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (resolve),
    .clear_i    (mispred),
    .head_dat_o (head_raw),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    state_d       = state_q;
    upd_branch_d  = resolve;
    upd_pc_d      = resolve ? head_ent.pc : '0;
    upd_taken_d   = resolve && res_taken;
    flush_d       = mispred;
    redirect_d    = '0;
    underflow_d   = underflow_q || (in_run && res_valid && empty);
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (resolve && (branch_cnt_q != '1))  branch_cnt_d  = branch_cnt_q + 1'b1;
    if (mispred && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    if (mispred) redirect_d = res_taken ? res_target : head_ent.pc + 1'b1;

    case (state_q)
      RUN:     if (mispred) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      live_q        <= 1'b0;
      upd_branch_q  <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      underflow_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      live_q        <= 1'b1;
      upd_branch_q  <= upd_branch_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      underflow_q   <= underflow_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign upd_branch       = upd_branch_q;
  assign upd_pc           = upd_pc_q;
  assign upd_taken        = upd_taken_q;
  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign underflow_err    = underflow_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and random stimulus against a queue-based behavioural model of the branch resolve unit.
module tb_branch_resolve_unit;

  localparam int PC_W  = 6;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } br_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             pred_valid, pred_taken, pred_ready;
  logic [PC_W-1:0]  pred_pc, pred_target;
  logic             res_valid, res_taken;
  logic [PC_W-1:0]  res_target;
  logic             upd_branch, upd_taken, flush, underflow_err;
  logic [PC_W-1:0]  upd_pc, redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_branch(upd_branch), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .underflow_err(underflow_err),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state
  br_t             m_q[$];
  bit              m_live, m_inflush;
  bit              e_upd, e_upd_tk, e_flush, e_uf;
  logic [PC_W-1:0] e_upd_pc, e_redir;
  int              e_bc, e_mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_live = 0; m_inflush = 0;
    e_upd = 0; e_upd_tk = 0; e_flush = 0; e_uf = 0;
    e_upd_pc = '0; e_redir = '0; e_bc = 0; e_mc = 0;
  endtask

  task automatic check_outputs();
    chk("upd_branch", upd_branch, e_upd);
    if (e_upd) begin
      chk("upd_pc", upd_pc, e_upd_pc);
      chk("upd_taken", upd_taken, e_upd_tk);
    end
    chk("flush", flush, e_flush);
    chk("redirect_pc", redirect_pc, e_redir);
    chk("underflow_err", underflow_err, e_uf);
    chk("branch_count", branch_count, e_bc);
    chk("mispredict_count", mispredict_count, e_mc);
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic step(input logic pv, input logic [PC_W-1:0] ppc, input logic ptk,
                      input logic [PC_W-1:0] ptg, input logic rv, input logic rtk,
                      input logic [PC_W-1:0] rtg);
    br_t h;
    bit  res, mis, corr, full, rdy_strict, rdy_loose, accept;
    pred_valid = pv; pred_pc = ppc; pred_taken = ptk; pred_target = ptg;
    res_valid = rv; res_taken = rtk; res_target = rtg;
    #1;
    res  = !m_inflush && rv && (m_q.size() > 0);
    mis  = 0;
    h    = '{pc: '0, taken: 1'b0, target: '0};
    if (res) begin
      h   = m_q[0];
      mis = (h.taken != rtk) || (rtk && (h.target != rtg));
    end
    corr       = res && !mis;
    full       = (m_q.size() == DEPTH);
    rdy_strict = m_live && !m_inflush && !full;
    rdy_loose  = m_live && !m_inflush && (!full || corr);
    chk("pred_ready", {31'd0, (pred_ready === rdy_strict) || (pred_ready === rdy_loose)}, 32'd1);
    accept = pv && (pred_ready === 1'b1);

    e_upd    = res;
    e_upd_pc = h.pc;
    e_upd_tk = rtk;
    e_flush  = mis;
    e_redir  = '0;
    if (mis) e_redir = rtk ? rtg : PC_W'((int'(h.pc) + 1) % 64);
    if (res && e_bc < 65535) e_bc++;
    if (mis && e_mc < 65535) e_mc++;
    if (!m_inflush && rv && m_q.size() == 0) e_uf = 1;
    if (res) void'(m_q.pop_front());
    if (mis) m_q.delete();
    else if (accept) m_q.push_back('{pc: ppc, taken: ptk, target: ptg});
    m_inflush = mis;
    m_live    = 1;

    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, '0);
  endtask

  // Asserted between clock edges so the clear must be asynchronous.
  task automatic pulse_reset();
    pred_valid = 0; res_valid = 0;
    #2 reset = 1;
    model_clear();
    #1;
    check_outputs();
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_upd_taken", upd_taken, 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    pred_valid = 0; pred_pc = '0; pred_taken = 0; pred_target = '0;
    res_valid = 0; res_taken = 0; res_target = '0;
    model_clear();
    #2;
    check_outputs();
    chk("reset_pred_ready", pred_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    idle();

    // Correct taken prediction
    step(1, 6'd5, 1, 6'd20, 0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 6'd20);
    chk("dir_bc1", branch_count, 1);

    // Not-taken prediction resolved taken, with two younger entries discarded
    step(1, 6'd8, 0, 6'd3, 0, 0, '0);
    step(1, 6'd9, 0, 6'd1, 0, 0, '0);
    step(1, 6'd10, 1, 6'd2, 0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 6'd40);
    chk("dir_redir40", redirect_pc, 40);
    step(1, 6'd11, 0, '0, 1, 0, '0);
    idle();

    // PC wrap on a not-taken correction
    step(1, 6'd63, 1, 6'd10, 0, 0, '0);
    step(0, '0, 0, '0, 1, 0, '0);
    chk("dir_wrap", redirect_pc, 0);
    idle();

    // Fill, attempt an extra push, then drain in order
    for (int i = 0; i < DEPTH + 1; i++) step(1, PC_W'(20 + i), 0, '0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 0, '0, 1, 0, '0);

    // Resolve on an empty queue
    step(0, '0, 0, '0, 1, 1, 6'd7);
    idle();
    chk("dir_uf_held", underflow_err, 1);

    // Reset with three entries in flight
    for (int i = 0; i < 3; i++) step(1, PC_W'(30 + i), 1, 6'd1, 0, 0, '0);
    pulse_reset();
    idle();

    // Push coinciding with a mispredicting resolve is discarded
    step(1, 6'd2, 0, '0, 0, 0, '0);
    step(1, 6'd12, 0, '0, 1, 1, 6'd5);
    idle();
    step(0, '0, 0, '0, 1, 0, '0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step($urandom_range(0, 9) < 6, PC_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                PC_W'($urandom_range(0, 3)), $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
                PC_W'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
